// File: rtl/apg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apg_pkg : shared mode/state encodings and sizing helper for the APG  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package apg_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_LOOPN   = 2'd1;
  localparam logic [1:0] MODE_CONT    = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  typedef logic [1:0] apg_state_t;

  localparam apg_state_t ST_IDLE = 2'd0;
  localparam apg_state_t ST_RUN  = 2'd1;
  localparam apg_state_t ST_DONE = 2'd2;

  function automatic int apg_addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apg_dpram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apg_dpram : simple dual-port RAM, one write port, registered read    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apg_dpram
  import apg_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = 256,
  parameter int AW    = apg_addr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset; read returns pre-write data on collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/apg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apg_sequencer : pattern generator with per-sample input capture      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apg_sequencer
  import apg_pkg::*;
#(
  parameter int NUM_SIG  = 14,
  parameter int NUM_SAMP = 256,
  parameter int DIV_W    = 16,
  parameter int LOOP_W   = 16
) (
  input  logic                        axi_clk,
  input  logic                        axi_resetn,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_SAMP)-1:0] wr_addr,
  input  logic [NUM_SIG-1:0]          wr_data,
  input  logic [$clog2(NUM_SAMP)-1:0] cap_rd_addr,
  output logic [NUM_SIG-1:0]          cap_rd_data,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  mode,
  input  logic [$clog2(NUM_SAMP):0]   n_samp,
  input  logic [LOOP_W-1:0]           loop_cnt,
  input  logic [DIV_W-1:0]            clk_div,
  input  logic [NUM_SIG-1:0]          idle_val,
  output logic [NUM_SIG-1:0]          output_signals,
  input  logic [NUM_SIG-1:0]          input_signals,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic                        err,
  output logic [LOOP_W-1:0]           loops_done,
  output logic [$clog2(NUM_SAMP)-1:0] samp_idx
);

  localparam int AW = apg_addr_w(NUM_SAMP);

  localparam logic [AW:0]     c_nsamp_max = (AW+1)'(NUM_SAMP);
  localparam logic [AW:0]     c_n_one     = (AW+1)'(1);
  localparam logic [AW-1:0]   c_idx_one   = AW'(1);
  localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);
  localparam logic [LOOP_W:0] c_loop_one  = (LOOP_W+1)'(1);

  apg_state_t          state_q, state_d;
  logic                prime_q, prime_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [LOOP_W-1:0]   loops_q, loops_d;
  logic [NUM_SIG-1:0]  out_q, out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                err_q, err_d;
  logic [1:0]          mode_q, mode_d;
  logic [AW:0]         n_q, n_d;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic [DIV_W-1:0]    div_lat_q, div_lat_d;
  logic [NUM_SIG-1:0]  idle_q, idle_d;

  logic                w_cfg_ok;
  logic                w_last;
  logic                w_finish;
  logic [LOOP_W:0]     w_loops_inc;
  logic [LOOP_W:0]     w_loop_tgt;
  logic [AW-1:0]       w_pat_raddr;
  logic [NUM_SIG-1:0]  w_pat_rdata;
  logic                w_pat_we;
  logic                w_cap_we;

  assign w_cfg_ok    = (n_samp != '0) && (n_samp <= c_nsamp_max) && (mode != MODE_RSVD);
  assign w_last      = ({1'b0, idx_q} == (n_q - c_n_one));
  assign w_loops_inc = {1'b0, loops_q} + c_loop_one;
  assign w_loop_tgt  = (loop_q == '0) ? c_loop_one : {1'b0, loop_q};

  always_comb begin
    w_finish = 1'b0;
    case (mode_q)
      MODE_ONESHOT: w_finish = 1'b1;
      MODE_LOOPN:   w_finish = (w_loops_inc >= w_loop_tgt);
      MODE_CONT:    w_finish = 1'b0;
      default:      w_finish = 1'b0;
    endcase
  end

  assign w_pat_we = wr_en && (state_q == ST_IDLE);
  assign w_cap_we = (state_q == ST_RUN) && !prime_q && (div_q == '0);

  always_comb begin
    state_d   = state_q;
    prime_d   = 1'b0;
    idx_d     = idx_q;
    div_d     = div_q;
    loops_d   = loops_q;
    out_d     = out_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    err_d     = err_q;
    mode_d    = mode_q;
    n_d       = n_q;
    loop_d    = loop_q;
    div_lat_d = div_lat_q;
    idle_d    = idle_q;

    case (state_q)
      ST_IDLE: begin
        out_d = idle_val;
        if (start && !stop) begin
          if (w_cfg_ok) begin
            state_d   = ST_RUN;
            prime_d   = 1'b1;
            idx_d     = '0;
            div_d     = '0;
            loops_d   = '0;
            aborted_d = 1'b0;
            err_d     = 1'b0;
            mode_d    = mode;
            n_d       = n_samp;
            loop_d    = loop_cnt;
            div_lat_d = clk_div;
            idle_d    = idle_val;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d   = ST_IDLE;
          out_d     = idle_val;
          aborted_d = 1'b1;
        end else if (prime_q) begin
          // Pattern RAM already holds sample 0 from the address parked at 0 in IDLE.
          out_d = w_pat_rdata;
          idx_d = '0;
          div_d = '0;
        end else if (div_q == div_lat_q) begin
          div_d = '0;
          if (w_last) begin
            loops_d = (&loops_q) ? loops_q : w_loops_inc[LOOP_W-1:0];
            if (w_finish) begin
              state_d = ST_DONE;
              out_d   = idle_q;
              done_d  = 1'b1;
            end else begin
              idx_d = '0;
              out_d = w_pat_rdata;
            end
          end else begin
            idx_d = idx_q + c_idx_one;
            out_d = w_pat_rdata;
          end
        end else begin
          div_d = div_q + c_div_one;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        out_d   = idle_val;
      end

      default: begin
        state_d = ST_IDLE;
        out_d   = idle_val;
      end
    endcase

    if (wr_en && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // Prefetch the sample that follows the one becoming visible after this edge.
  always_comb begin
    w_pat_raddr = '0;
    if (state_q == ST_RUN) begin
      if ({1'b0, idx_d} == (n_q - c_n_one)) begin
        w_pat_raddr = '0;
      end else begin
        w_pat_raddr = idx_d + c_idx_one;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= ST_IDLE;
      prime_q   <= 1'b0;
      idx_q     <= '0;
      div_q     <= '0;
      loops_q   <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      n_q       <= '0;
      loop_q    <= '0;
      div_lat_q <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      prime_q   <= prime_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      loops_q   <= loops_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
      mode_q    <= mode_d;
      n_q       <= n_d;
      loop_q    <= loop_d;
      div_lat_q <= div_lat_d;
      idle_q    <= idle_d;
    end
  end

  apg_dpram #(
    .WIDTH (NUM_SIG),
    .DEPTH (NUM_SAMP),
    .AW    (AW)
  ) u_pattern_ram (
    .clk_i   (axi_clk),
    .we_i    (w_pat_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (w_pat_raddr),
    .rdata_o (w_pat_rdata)
  );

  apg_dpram #(
    .WIDTH (NUM_SIG),
    .DEPTH (NUM_SAMP),
    .AW    (AW)
  ) u_capture_ram (
    .clk_i   (axi_clk),
    .we_i    (w_cap_we),
    .waddr_i (idx_q),
    .wdata_i (input_signals),
    .raddr_i (cap_rd_addr),
    .rdata_o (cap_rd_data)
  );

  assign output_signals = out_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign err            = err_q;
  assign loops_done     = loops_q;
  assign samp_idx       = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_apg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apg_sequencer : directed self-checking bench for apg_sequencer    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_apg_sequencer;

  localparam int NUM_SIG  = 14;
  localparam int NUM_SAMP = 256;
  localparam int DIV_W    = 16;
  localparam int LOOP_W   = 16;
  localparam int AW       = 8;
  localparam logic [NUM_SIG-1:0] IDLE_V = 14'h1555;

  logic               axi_clk = 1'b0;
  logic               axi_resetn = 1'b0;
  logic               wr_en = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic [NUM_SIG-1:0] wr_data = '0;
  logic [AW-1:0]      cap_rd_addr = '0;
  logic [NUM_SIG-1:0] cap_rd_data;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [AW:0]        n_samp = '0;
  logic [LOOP_W-1:0]  loop_cnt = '0;
  logic [DIV_W-1:0]   clk_div = '0;
  logic [NUM_SIG-1:0] idle_val = IDLE_V;
  logic [NUM_SIG-1:0] output_signals;
  logic [NUM_SIG-1:0] input_signals = '0;
  logic               busy, done, aborted, err;
  logic [LOOP_W-1:0]  loops_done;
  logic [AW-1:0]      samp_idx;

  int vec  = 0;
  int miss = 0;

  apg_sequencer #(
    .NUM_SIG (NUM_SIG), .NUM_SAMP (NUM_SAMP), .DIV_W (DIV_W), .LOOP_W (LOOP_W)
  ) dut (
    .axi_clk (axi_clk), .axi_resetn (axi_resetn),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .cap_rd_addr (cap_rd_addr), .cap_rd_data (cap_rd_data),
    .start (start), .stop (stop), .mode (mode),
    .n_samp (n_samp), .loop_cnt (loop_cnt), .clk_div (clk_div), .idle_val (idle_val),
    .output_signals (output_signals), .input_signals (input_signals),
    .busy (busy), .done (done), .aborted (aborted), .err (err),
    .loops_done (loops_done), .samp_idx (samp_idx)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  // Returns one step after the edge that samples start.
  task automatic do_start(input logic [1:0] m, input logic [AW:0] n,
                          input logic [LOOP_W-1:0] lc, input logic [DIV_W-1:0] dv);
    mode = m; n_samp = n; loop_cnt = lc; clk_div = dv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0;
    #3;
    vec++;
    if (output_signals !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      miss++; $display("FAIL reset_outs: out=%h busy=%b done=%b, want 0/0/0", output_signals, busy, done);
    end
    vec++;
    if (aborted !== 1'b0 || err !== 1'b0 || loops_done !== '0 || samp_idx !== '0) begin
      miss++; $display("FAIL reset_status: aborted=%b err=%b loops=%h idx=%h, want all 0",
                       aborted, err, loops_done, samp_idx);
    end
    tick();
    axi_resetn = 1'b1;
    tick();
    vec++;
    if (output_signals !== IDLE_V || busy !== 1'b0) begin
      miss++; $display("FAIL reset_release: out=%h busy=%b, want %h/0", output_signals, busy, IDLE_V);
    end
  endtask

  task automatic load_pattern();
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = NUM_SIG'(k);
      tick();
    end
    wr_en = 1'b0;
    tick();
  endtask

  task automatic test_oneshot();
    do_start(2'd0, 9'd4, 16'd0, 16'd0);
    vec++;
    if (busy !== 1'b1 || output_signals !== IDLE_V) begin
      miss++; $display("FAIL oneshot_prime: busy=%b out=%h, want 1/%h", busy, output_signals, IDLE_V);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++;
      if (output_signals !== NUM_SIG'(i) || done !== 1'b0) begin
        miss++; $display("FAIL oneshot_sample%0d: out=%h done=%b, want %h/0", i, output_signals, done, NUM_SIG'(i));
      end
    end
    tick();
    vec++;
    if (done !== 1'b1 || output_signals !== IDLE_V) begin
      miss++; $display("FAIL oneshot_done: done=%b out=%h, want 1/%h", done, output_signals, IDLE_V);
    end
    tick();
    vec++;
    if (done !== 1'b0 || busy !== 1'b0 || loops_done !== 16'd1 || output_signals !== IDLE_V) begin
      miss++; $display("FAIL oneshot_after: done=%b busy=%b loops=%0d out=%h, want 0/0/1/%h",
                       done, busy, loops_done, output_signals, IDLE_V);
    end
  endtask

  task automatic test_loopn();
    logic [NUM_SIG-1:0] exp;
    int done_cnt;
    done_cnt = 0;
    do_start(2'd1, 9'd3, 16'd2, 16'd2);
    n_samp = 9'd7; loop_cnt = 16'd9; clk_div = 16'd0;
    for (int j = 0; j < 18; j++) begin
      tick();
      exp = NUM_SIG'((j / 3) % 3);
      if (done === 1'b1) done_cnt++;
      vec++;
      if (output_signals !== exp) begin
        miss++; $display("FAIL loopn_cycle%0d: out=%h, want %h", j, output_signals, exp);
      end
    end
    tick();
    if (done === 1'b1) done_cnt++;
    vec++;
    if (done !== 1'b1 || output_signals !== IDLE_V) begin
      miss++; $display("FAIL loopn_done: done=%b out=%h, want 1/%h", done, output_signals, IDLE_V);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    vec++;
    if (done_cnt != 1 || loops_done !== 16'd2 || busy !== 1'b0) begin
      miss++; $display("FAIL loopn_end: done_pulses=%0d loops=%0d busy=%b, want 1/2/0", done_cnt, loops_done, busy);
    end
  endtask

  task automatic test_stop();
    int done_cnt;
    done_cnt = 0;
    do_start(2'd2, 9'd4, 16'd0, 16'd3);
    for (int j = 0; j < 6; j++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    vec++;
    if (output_signals !== 14'd1 || samp_idx !== 8'd1) begin
      miss++; $display("FAIL stop_pre: out=%h idx=%0d, want 1/1", output_signals, samp_idx);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vec++;
    if (output_signals !== IDLE_V || aborted !== 1'b1 || busy !== 1'b0) begin
      miss++; $display("FAIL stop_next: out=%h aborted=%b busy=%b, want %h/1/0", output_signals, aborted, busy, IDLE_V);
    end
    for (int j = 0; j < 4; j++) begin
      if (done === 1'b1) done_cnt++;
      tick();
    end
    vec++;
    if (done_cnt != 0) begin
      miss++; $display("FAIL stop_nodone: done pulses=%0d, want 0", done_cnt);
    end
  endtask

  task automatic test_start_stop();
    mode = 2'd0; n_samp = 9'd4;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    vec++;
    if (busy !== 1'b0 || err !== 1'b0 || output_signals !== IDLE_V) begin
      miss++; $display("FAIL start_stop: busy=%b err=%b out=%h, want 0/0/%h", busy, err, output_signals, IDLE_V);
    end
  endtask

  task automatic test_errors();
    do_start(2'd0, 9'd0, 16'd0, 16'd0);
    vec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miss++; $display("FAIL err_nsamp0: err=%b busy=%b, want 1/0", err, busy);
    end
    do_start(2'd2, 9'd2, 16'd0, 16'd0);
    vec++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miss++; $display("FAIL err_clear: err=%b busy=%b, want 0/1", err, busy);
    end
    mode = 2'd0; n_samp = 9'd1; start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miss++; $display("FAIL err_start_busy: err=%b busy=%b, want 0/1", err, busy);
    end
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 14'h3FFF;
    tick();
    wr_en = 1'b0;
    vec++;
    if (err !== 1'b1) begin
      miss++; $display("FAIL err_wr_busy: err=%b, want 1", err);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    do_start(2'd0, 9'd1, 16'd0, 16'd0);
    tick();
    vec++;
    if (output_signals !== 14'd0) begin
      miss++; $display("FAIL err_pattern_kept: out=%h, want 0000", output_signals);
    end
    tick();
    tick();
    do_start(2'd3, 9'd4, 16'd0, 16'd0);
    vec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miss++; $display("FAIL err_mode3: err=%b busy=%b, want 1/0", err, busy);
    end
  endtask

  task automatic test_capture();
    input_signals = 14'h111;
    do_start(2'd0, 9'd4, 16'd0, 16'd1);
    tick(); tick(); tick();
    input_signals = 14'h2A5;
    vec++;
    if (output_signals !== 14'd1 || samp_idx !== 8'd1) begin
      miss++; $display("FAIL cap_sample1: out=%h idx=%0d, want 1/1", output_signals, samp_idx);
    end
    tick(); tick();
    input_signals = 14'h0F0;
    for (int j = 0; j < 5; j++) tick();
    cap_rd_addr = 8'd1;
    tick();
    vec++;
    if (cap_rd_data !== 14'h2A5) begin
      miss++; $display("FAIL cap_addr1: got %h, want 2a5", cap_rd_data);
    end
    cap_rd_addr = 8'd0;
    tick();
    vec++;
    if (cap_rd_data !== 14'h111) begin
      miss++; $display("FAIL cap_addr0: got %h, want 111", cap_rd_data);
    end
    cap_rd_addr = 8'd2;
    tick();
    vec++;
    if (cap_rd_data !== 14'h0F0) begin
      miss++; $display("FAIL cap_addr2: got %h, want 0f0", cap_rd_data);
    end
  endtask

  task automatic test_reset_midrun();
    int done_cnt;
    done_cnt = 0;
    do_start(2'd2, 9'd4, 16'd0, 16'd0);
    tick(); tick(); tick();
    vec++;
    if (output_signals !== 14'd2) begin
      miss++; $display("FAIL rstrun_pre: out=%h, want 2", output_signals);
    end
    #2;
    axi_resetn = 1'b0;
    #1;
    vec++;
    if (output_signals !== '0 || busy !== 1'b0 || done !== 1'b0 || samp_idx !== '0) begin
      miss++; $display("FAIL rstrun_async: out=%h busy=%b done=%b idx=%0d, want 0/0/0/0",
                       output_signals, busy, done, samp_idx);
    end
    tick();
    axi_resetn = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    vec++;
    if (output_signals !== IDLE_V || busy !== 1'b0 || done_cnt != 0) begin
      miss++; $display("FAIL rstrun_after: out=%h busy=%b done_pulses=%0d, want %h/0/0",
                       output_signals, busy, done_cnt, IDLE_V);
    end
  endtask

  initial begin
    test_reset();
    load_pattern();
    test_oneshot();
    test_loopn();
    test_stop();
    test_start_stop();
    test_errors();
    test_capture();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
